// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Main sequencer of the multicycle ARM core. Steps each
//               instruction through fetch / decode / execute / writeback and
//               drives the datapath selects, write enables and the AluDecoder
//               alu_op input. Memory states wait on mem_ready, with an
//               optional timeout that raises a sticky mem_err flag.
// Ports       : clk, reset_n (async, active low)
//               op[1:0], funct[5:0]  - instruction fields instr[27:26], [25:20]
//               mem_ready            - memory access completes this cycle
//               ir_write, next_pc    - fetch enables
//               adr_src, alu_src_a, alu_src_b, result_src, alu_op - selects
//               reg_w, mem_w, branch - write/branch requests (pre cond-gating)
//               instr_done, illegal  - one-cycle status pulses
//               mem_err              - sticky memory timeout flag
//               state[3:0]           - current state code
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       next_pc,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       alu_op,
    output logic       reg_w,
    output logic       mem_w,
    output logic       branch,
    output logic       instr_done,
    output logic       illegal,
    output logic       mem_err,
    output logic [3:0] state
);

    localparam logic [3:0] c_FETCH    = 4'd0;
    localparam logic [3:0] c_DECODE   = 4'd1;
    localparam logic [3:0] c_MEMADR   = 4'd2;
    localparam logic [3:0] c_MEMREAD  = 4'd3;
    localparam logic [3:0] c_MEMWB    = 4'd4;
    localparam logic [3:0] c_MEMWRITE = 4'd5;
    localparam logic [3:0] c_EXECR    = 4'd6;
    localparam logic [3:0] c_EXECI    = 4'd7;
    localparam logic [3:0] c_ALUWB    = 4'd8;
    localparam logic [3:0] c_BRANCH   = 4'd9;

    // The counter only has to reach TIMEOUT-1.
    localparam int                 c_CNT_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LIMIT = (TIMEOUT > 0) ? c_CNT_W'(TIMEOUT - 1) : '0;

    logic [3:0]         r_state;
    logic [3:0]         w_next;
    logic [c_CNT_W-1:0] r_wait_cnt;
    logic               r_mem_err;
    logic               w_mem_wait;
    logic               w_timeout;

    // Raw enables before reset gating.
    logic w_ir_write;
    logic w_next_pc;
    logic w_reg_w;
    logic w_mem_w;
    logic w_branch;
    logic w_instr_done;
    logic w_illegal;

    assign w_mem_wait = (r_state == c_FETCH) || (r_state == c_MEMREAD) ||
                        (r_state == c_MEMWRITE);

    // A mem_ready arriving in the limit cycle takes priority over the timeout.
    assign w_timeout  = (TIMEOUT > 0) && w_mem_wait && !mem_ready &&
                        (r_wait_cnt == c_CNT_LIMIT);

    // ------------------------------------------------------------------------
    // State register, wait counter and sticky error flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_FETCH;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else if (w_timeout) begin
            r_state    <= c_FETCH;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b1;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_wait_cnt <= '0;
            end else if (w_mem_wait && !mem_ready) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_next       = c_FETCH;
        w_ir_write   = 1'b0;
        w_next_pc    = 1'b0;
        adr_src      = 1'b0;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        result_src   = 2'b00;
        alu_op       = 1'b0;
        w_reg_w      = 1'b0;
        w_mem_w      = 1'b0;
        w_branch     = 1'b0;
        w_instr_done = 1'b0;
        w_illegal    = 1'b0;

        case (r_state)
            c_FETCH: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                w_ir_write = mem_ready;
                w_next_pc  = mem_ready;
                w_next     = mem_ready ? c_DECODE : c_FETCH;
            end
            c_DECODE: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                case (op)
                    2'b00:   w_next = funct[5] ? c_EXECI : c_EXECR;
                    2'b01:   w_next = c_MEMADR;
                    2'b10:   w_next = c_BRANCH;
                    default: begin
                        w_next    = c_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            c_MEMADR: begin
                alu_src_b = 2'b01;
                w_next    = funct[0] ? c_MEMREAD : c_MEMWRITE;
            end
            c_MEMREAD: begin
                adr_src = 1'b1;
                w_next  = mem_ready ? c_MEMWB : c_MEMREAD;
            end
            c_MEMWB: begin
                result_src   = 2'b01;
                w_reg_w      = 1'b1;
                w_instr_done = 1'b1;
            end
            c_MEMWRITE: begin
                adr_src      = 1'b1;
                w_mem_w      = 1'b1;
                w_instr_done = mem_ready;
                w_next       = mem_ready ? c_FETCH : c_MEMWRITE;
            end
            c_EXECR: begin
                alu_op = 1'b1;
                w_next = c_ALUWB;
            end
            c_EXECI: begin
                alu_src_b = 2'b01;
                alu_op    = 1'b1;
                w_next    = c_ALUWB;
            end
            c_ALUWB: begin
                w_reg_w      = 1'b1;
                w_instr_done = 1'b1;
            end
            c_BRANCH: begin
                alu_src_b    = 2'b01;
                result_src   = 2'b10;
                w_branch     = 1'b1;
                w_instr_done = 1'b1;
            end
            default: begin
                // Unreachable codes recover to FETCH with all outputs idle.
                w_next = c_FETCH;
            end
        endcase
    end

    // Enables are forced low combinationally so an asserted reset silences
    // them at once rather than at the next clock edge.
    assign ir_write   = w_ir_write   & reset_n;
    assign next_pc    = w_next_pc    & reset_n;
    assign reg_w      = w_reg_w      & reset_n;
    assign mem_w      = w_mem_w      & reset_n;
    assign branch     = w_branch     & reset_n;
    assign instr_done = w_instr_done & reset_n;
    assign illegal    = w_illegal    & reset_n;
    assign mem_err    = r_mem_err;
    assign state      = r_state;

endmodule
`default_nettype wire
